// File: rtl/irrigacao_multizona.sv
// -----------------------------------------------------------------------------
// irrigacao_multizona
//
// Multi-zone irrigation sequencer sharing one reservoir. A program fills the
// tank, then waters every enabled zone in ascending order (sprinkler or drip)
// for a programmed number of cycles, refilling whenever the tank runs low
// mid-zone, and finishes with a timed cleaning cycle. A fill timeout or an
// external fault lands in a latched error state that Start acknowledges.
//
// Ports:
//   Clock, Reset        rising-edge clock, asynchronous active-high reset
//   Start               start request in OCIOSO, acknowledge in ERRO
//   Nivel_Cheio/Baixo   tank full / tank low sensors
//   Erro_In             external fault
//   Agro_En             agrochemical injection on sprinkler zones
//   Zona_Habilita/Modo  per-zone enable and mode (1 = aspersao, 0 = gotejamento)
//   Tempo_Rega          watering cycles per zone
//   S_*                 valves, pump and status; Moore decode of state/pointer
//   S_Zona              current zone pointer
//   S_Fim               registered one-cycle pulse at program completion
// -----------------------------------------------------------------------------
module irrigacao_multizona #(
  parameter int NUM_ZONES    = 4,
  parameter int TIME_W       = 8,
  parameter int CLEAN_CYCLES = 16,
  parameter int FILL_TIMEOUT = 200
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         Start,
  input  logic                         Nivel_Cheio,
  input  logic                         Nivel_Baixo,
  input  logic                         Erro_In,
  input  logic                         Agro_En,
  input  logic [NUM_ZONES-1:0]         Zona_Habilita,
  input  logic [NUM_ZONES-1:0]         Zona_Modo,
  input  logic [TIME_W-1:0]            Tempo_Rega,
  output logic                         S_Enchendo,
  output logic [NUM_ZONES-1:0]         S_Aspersao,
  output logic [NUM_ZONES-1:0]         S_Gotejamento,
  output logic                         S_Agro,
  output logic                         S_Limpeza,
  output logic                         S_SaidaLimpeza,
  output logic                         S_Erro,
  output logic                         S_Ocupado,
  output logic [$clog2(NUM_ZONES)-1:0] S_Zona,
  output logic                         S_Fim
);

  localparam int ZW = $clog2(NUM_ZONES);
  localparam int FW = $clog2(FILL_TIMEOUT + 1);
  localparam int CW = $clog2(CLEAN_CYCLES + 1);

  typedef enum logic [2:0] {
    OCIOSO, ENCHENDO, CHEIO, REGANDO, LIMPEZA, ERRO
  } state_t;

  state_t                state;
  logic [ZW-1:0]         ptr;
  logic [TIME_W-1:0]     timer;
  logic [FW-1:0]         fill_cnt;
  logic [CW-1:0]         clean_cnt;
  logic                  paused;
  logic                  fim_q;

  // Program configuration captured at Start; the live inputs are ignored
  // until the next program.
  logic [NUM_ZONES-1:0]  en_q;
  logic [NUM_ZONES-1:0]  modo_q;
  logic [TIME_W-1:0]     tempo_q;
  logic                  agro_q;

  // Lowest enabled zone at or above the pointer (used in CHEIO).
  logic                  found;
  logic [ZW-1:0]         next_zone;

  // NOTE: every variable assigned in always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    found     = 1'b0;
    next_zone = ptr;
    for (int i = NUM_ZONES - 1; i >= 0; i--) begin
      if (i >= int'(ptr) && en_q[i] && tempo_q != '0) begin
        found     = 1'b1;
        next_zone = ZW'(i);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= OCIOSO;
      ptr       <= '0;
      timer     <= '0;
      fill_cnt  <= '0;
      clean_cnt <= '0;
      paused    <= 1'b0;
      fim_q     <= 1'b0;
      en_q      <= '0;
      modo_q    <= '0;
      tempo_q   <= '0;
      agro_q    <= 1'b0;
    end else begin
      fim_q <= 1'b0;
      case (state)
        OCIOSO: begin
          if (Start) begin
            en_q     <= Zona_Habilita;
            modo_q   <= Zona_Modo;
            tempo_q  <= Tempo_Rega;
            agro_q   <= Agro_En;
            ptr      <= '0;
            fill_cnt <= '0;
            paused   <= 1'b0;
            state    <= ENCHENDO;
          end
        end

        ERRO: begin
          if (!Erro_In && Start) state <= OCIOSO;
        end

        default: begin
          // External fault overrides every other transition.
          if (Erro_In) begin
            state <= ERRO;
          end else begin
            case (state)
              ENCHENDO: begin
                fill_cnt <= fill_cnt + FW'(1);
                if (Nivel_Cheio)                          state <= CHEIO;
                else if (fill_cnt == FW'(FILL_TIMEOUT - 1)) state <= ERRO;
              end

              CHEIO: begin
                if (paused) begin
                  // Resume the interrupted zone with its remaining time.
                  paused <= 1'b0;
                  state  <= REGANDO;
                end else if (found) begin
                  ptr   <= next_zone;
                  timer <= tempo_q;
                  state <= REGANDO;
                end else begin
                  clean_cnt <= '0;
                  state     <= LIMPEZA;
                end
              end

              REGANDO: begin
                if (timer == TIME_W'(1)) begin
                  if (ptr == ZW'(NUM_ZONES - 1)) begin
                    clean_cnt <= '0;
                    state     <= LIMPEZA;
                  end else begin
                    ptr   <= ptr + ZW'(1);
                    state <= CHEIO;
                  end
                end else begin
                  // This cycle counts as watered even when pausing.
                  timer <= timer - TIME_W'(1);
                  if (Nivel_Baixo) begin
                    paused   <= 1'b1;
                    fill_cnt <= '0;
                    state    <= ENCHENDO;
                  end
                end
              end

              LIMPEZA: begin
                if (clean_cnt == CW'(CLEAN_CYCLES - 1)) begin
                  fim_q <= 1'b1;
                  state <= OCIOSO;
                end else begin
                  clean_cnt <= clean_cnt + CW'(1);
                end
              end

              default: state <= OCIOSO;
            endcase
          end
        end
      endcase
    end
  end

  // Moore output decode from registered state, pointer and configuration.
  logic [NUM_ZONES-1:0] zone_onehot;
  logic                 regando;

  assign zone_onehot    = NUM_ZONES'(1) << ptr;
  assign regando        = (state == REGANDO);

  assign S_Enchendo     = (state == ENCHENDO);
  assign S_Aspersao     = (regando &&  modo_q[ptr]) ? zone_onehot : '0;
  assign S_Gotejamento  = (regando && !modo_q[ptr]) ? zone_onehot : '0;
  assign S_Agro         = regando && modo_q[ptr] && agro_q;
  assign S_Limpeza      = (state == LIMPEZA);
  assign S_SaidaLimpeza = (state == LIMPEZA);
  assign S_Erro         = (state == ERRO);
  assign S_Ocupado      = (state != OCIOSO);
  assign S_Zona         = ptr;
  assign S_Fim          = fim_q;

endmodule

// File: tb/tb_irrigacao_multizona.sv
// -----------------------------------------------------------------------------
// tb_irrigacao_multizona
//
// Directed bench for irrigacao_multizona (NUM_ZONES=4, CLEAN_CYCLES=4,
// FILL_TIMEOUT=10). Each step drives the sensors/commands, clocks once and
// compares the whole output bundle against a hand-computed expectation.
// -----------------------------------------------------------------------------
module tb_irrigacao_multizona;

  logic       Clock;
  logic       Reset;
  logic       Start;
  logic       Nivel_Cheio;
  logic       Nivel_Baixo;
  logic       Erro_In;
  logic       Agro_En;
  logic [3:0] Zona_Habilita;
  logic [3:0] Zona_Modo;
  logic [7:0] Tempo_Rega;
  logic       S_Enchendo;
  logic [3:0] S_Aspersao;
  logic [3:0] S_Gotejamento;
  logic       S_Agro;
  logic       S_Limpeza;
  logic       S_SaidaLimpeza;
  logic       S_Erro;
  logic       S_Ocupado;
  logic [1:0] S_Zona;
  logic       S_Fim;

  irrigacao_multizona #(
    .NUM_ZONES   (4),
    .TIME_W      (8),
    .CLEAN_CYCLES(4),
    .FILL_TIMEOUT(10)
  ) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .Start         (Start),
    .Nivel_Cheio   (Nivel_Cheio),
    .Nivel_Baixo   (Nivel_Baixo),
    .Erro_In       (Erro_In),
    .Agro_En       (Agro_En),
    .Zona_Habilita (Zona_Habilita),
    .Zona_Modo     (Zona_Modo),
    .Tempo_Rega    (Tempo_Rega),
    .S_Enchendo    (S_Enchendo),
    .S_Aspersao    (S_Aspersao),
    .S_Gotejamento (S_Gotejamento),
    .S_Agro        (S_Agro),
    .S_Limpeza     (S_Limpeza),
    .S_SaidaLimpeza(S_SaidaLimpeza),
    .S_Erro        (S_Erro),
    .S_Ocupado     (S_Ocupado),
    .S_Zona        (S_Zona),
    .S_Fim         (S_Fim)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Output bundle: {enchendo, aspersao[3:0], gotejamento[3:0], agro,
  //                 limpeza, saida_limpeza, erro, ocupado, zona[1:0], fim}
  typedef logic [16:0] obs_t;
  obs_t obs;
  assign obs = {S_Enchendo, S_Aspersao, S_Gotejamento, S_Agro, S_Limpeza,
                S_SaidaLimpeza, S_Erro, S_Ocupado, S_Zona, S_Fim};

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic obs_t e(input logic en, input logic [3:0] a,
                             input logic [3:0] g, input logic ag,
                             input logic lp, input logic er, input logic oc,
                             input logic [1:0] z, input logic f);
    return {en, a, g, ag, lp, lp, er, oc, z, f};
  endfunction

  function automatic obs_t f_ench(input logic [1:0] z);
    return e(1'b1, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, z, 1'b0);
  endfunction
  function automatic obs_t f_cheio(input logic [1:0] z);
    return e(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, z, 1'b0);
  endfunction
  function automatic obs_t f_asp(input logic [1:0] z, input logic ag);
    logic [3:0] one = 4'b0001;
    return e(1'b0, one << z, '0, ag, 1'b0, 1'b0, 1'b1, z, 1'b0);
  endfunction
  function automatic obs_t f_got(input logic [1:0] z);
    logic [3:0] one = 4'b0001;
    return e(1'b0, '0, one << z, 1'b0, 1'b0, 1'b0, 1'b1, z, 1'b0);
  endfunction
  function automatic obs_t f_limp(input logic [1:0] z);
    return e(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1, z, 1'b0);
  endfunction
  function automatic obs_t f_erro(input logic [1:0] z);
    return e(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1, z, 1'b0);
  endfunction
  function automatic obs_t f_idle(input logic [1:0] z, input logic f);
    return e(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, z, f);
  endfunction

  task automatic check(input string nm, input obs_t act, input obs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  // Drive inputs (just after an edge), clock once, sample 1 ns later.
  task automatic step(input logic st, input logic ch, input logic bx,
                      input logic er, input obs_t exp, input string nm);
    Start       = st;
    Nivel_Cheio = ch;
    Nivel_Baixo = bx;
    Erro_In     = er;
    @(posedge Clock);
    #1;
    check(nm, obs, exp);
  endtask

  task automatic config_prog(input logic [3:0] hab, input logic [3:0] modo,
                             input logic [7:0] tempo, input logic agro);
    Zona_Habilita = hab;
    Zona_Modo     = modo;
    Tempo_Rega    = tempo;
    Agro_En       = agro;
  endtask

  typedef struct {
    logic start;
    logic cheio;
    obs_t exp;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic st, input logic ch, input obs_t ex);
    vec_t v;
    v.start = st;
    v.cheio = ch;
    v.exp   = ex;
    vecs.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset = 1'b0;
    Start = 1'b0; Nivel_Cheio = 1'b0; Nivel_Baixo = 1'b0; Erro_In = 1'b0;
    config_prog(4'b0000, 4'b0000, 8'd0, 1'b0);

    // ---------------- reset state ----------------
    #2 Reset = 1'b1;
    #1 check("reset_async", obs, f_idle(2'd0, 1'b0));
    #9 Reset = 1'b0;
    @(posedge Clock);
    #1 check("reset_idle", obs, f_idle(2'd0, 1'b0));

    // ---------------- basic program (table) ----------------
    add(1'b1, 1'b0, f_ench(2'd0));
    for (int i = 0; i < 4; i++) add(1'b0, 1'b0, f_ench(2'd0));
    add(1'b0, 1'b1, f_cheio(2'd0));
    for (int i = 0; i < 3; i++) add(1'b0, 1'b1, f_asp(2'd0, 1'b1));
    add(1'b0, 1'b1, f_cheio(2'd1));
    for (int i = 0; i < 3; i++) add(1'b0, 1'b1, f_got(2'd1));
    add(1'b0, 1'b1, f_cheio(2'd2));
    for (int i = 0; i < 3; i++) add(1'b0, 1'b1, f_asp(2'd2, 1'b1));
    add(1'b0, 1'b1, f_cheio(2'd3));
    for (int i = 0; i < 3; i++) add(1'b0, 1'b1, f_got(2'd3));
    for (int i = 0; i < 4; i++) add(1'b0, 1'b1, f_limp(2'd3));
    add(1'b0, 1'b1, f_idle(2'd3, 1'b1));
    add(1'b0, 1'b1, f_idle(2'd3, 1'b0));

    config_prog(4'b1111, 4'b0101, 8'd3, 1'b1);
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].start, vecs[i].cheio, 1'b0, 1'b0, vecs[i].exp,
           $sformatf("basic[%0d]", i));
      // Live configuration changes after Start must not matter.
      if (i == 0) config_prog(4'b0000, 4'b1010, 8'd0, 1'b0);
    end

    // ---------------- zone skipping ----------------
    config_prog(4'b1010, 4'b0000, 8'd2, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, f_ench(2'd0),  "skip_ench");
    step(1'b0, 1'b1, 1'b0, 1'b0, f_cheio(2'd0), "skip_cheio0");
    step(1'b0, 1'b1, 1'b0, 1'b0, f_got(2'd1),   "skip_z1a");
    step(1'b0, 1'b1, 1'b0, 1'b0, f_got(2'd1),   "skip_z1b");
    step(1'b0, 1'b1, 1'b0, 1'b0, f_cheio(2'd2), "skip_cheio2");
    step(1'b0, 1'b1, 1'b0, 1'b0, f_got(2'd3),   "skip_z3a");
    step(1'b0, 1'b1, 1'b0, 1'b0, f_got(2'd3),   "skip_z3b");
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 1'b0, 1'b0, f_limp(2'd3), $sformatf("skip_limp%0d", i));
    step(1'b0, 1'b1, 1'b0, 1'b0, f_idle(2'd3, 1'b1), "skip_fim");

    // ---------------- Tempo_Rega = 0: straight to cleaning ----------------
    config_prog(4'b1111, 4'b0101, 8'd0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, f_ench(2'd0),  "t0_ench");
    step(1'b0, 1'b1, 1'b0, 1'b0, f_cheio(2'd0), "t0_cheio");
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 1'b0, 1'b0, f_limp(2'd0), $sformatf("t0_limp%0d", i));
    step(1'b0, 1'b1, 1'b0, 1'b0, f_idle(2'd0, 1'b1), "t0_fim");

    // ---------------- fill timeout ----------------
    config_prog(4'b1111, 4'b0000, 8'd3, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, f_ench(2'd0), "to_ench0");
    for (int i = 1; i < 10; i++)
      step(1'b0, 1'b0, 1'b0, 1'b0, f_ench(2'd0), $sformatf("to_ench%0d", i));
    step(1'b0, 1'b0, 1'b0, 1'b0, f_erro(2'd0),       "to_erro");
    step(1'b1, 1'b0, 1'b0, 1'b0, f_idle(2'd0, 1'b0), "to_ack");

    // ---------------- low-level pause ----------------
    config_prog(4'b0010, 4'b0010, 8'd5, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, f_ench(2'd0),        "pz_ench");
    step(1'b0, 1'b1, 1'b0, 1'b0, f_cheio(2'd0),       "pz_cheio");
    step(1'b0, 1'b1, 1'b0, 1'b0, f_asp(2'd1, 1'b0),   "pz_reg1");
    step(1'b0, 1'b1, 1'b0, 1'b0, f_asp(2'd1, 1'b0),   "pz_reg2");
    step(1'b0, 1'b0, 1'b1, 1'b0, f_ench(2'd1),        "pz_refill0");
    step(1'b0, 1'b0, 1'b0, 1'b0, f_ench(2'd1),        "pz_refill1");
    step(1'b0, 1'b1, 1'b0, 1'b0, f_cheio(2'd1),       "pz_cheio_resume");
    for (int i = 3; i <= 5; i++)
      step(1'b0, 1'b1, 1'b0, 1'b0, f_asp(2'd1, 1'b0), $sformatf("pz_reg%0d", i));
    step(1'b0, 1'b1, 1'b0, 1'b0, f_cheio(2'd2),       "pz_cheio2");
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 1'b0, 1'b0, f_limp(2'd2), $sformatf("pz_limp%0d", i));
    step(1'b0, 1'b1, 1'b0, 1'b0, f_idle(2'd2, 1'b1),  "pz_fim");

    // ---------------- error during watering ----------------
    config_prog(4'b0001, 4'b0001, 8'd4, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, f_ench(2'd0),        "er_ench");
    step(1'b0, 1'b1, 1'b0, 1'b0, f_cheio(2'd0),       "er_cheio");
    step(1'b0, 1'b1, 1'b0, 1'b0, f_asp(2'd0, 1'b1),   "er_reg");
    step(1'b0, 1'b1, 1'b0, 1'b1, f_erro(2'd0),        "er_erro");
    step(1'b1, 1'b1, 1'b0, 1'b1, f_erro(2'd0),        "er_hold");
    step(1'b1, 1'b1, 1'b0, 1'b0, f_idle(2'd0, 1'b0),  "er_ack");
    step(1'b0, 1'b1, 1'b0, 1'b1, f_idle(2'd0, 1'b0),  "er_idle_ignore");

    // ---------------- async reset during cleaning ----------------
    config_prog(4'b0001, 4'b0000, 8'd1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, f_ench(2'd0),  "rs_ench");
    step(1'b0, 1'b1, 1'b0, 1'b0, f_cheio(2'd0), "rs_cheio");
    step(1'b0, 1'b1, 1'b0, 1'b0, f_got(2'd0),   "rs_reg");
    step(1'b0, 1'b1, 1'b0, 1'b0, f_cheio(2'd1), "rs_cheio1");
    step(1'b0, 1'b1, 1'b0, 1'b0, f_limp(2'd1),  "rs_limp0");
    step(1'b0, 1'b1, 1'b0, 1'b0, f_limp(2'd1),  "rs_limp1");
    #2 Reset = 1'b1;
    #1 check("rs_immediate", obs, f_idle(2'd0, 1'b0));
    @(negedge Clock);
    Reset = 1'b0;
    @(posedge Clock);
    #1;
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b1, 1'b0, 1'b0, f_idle(2'd0, 1'b0), $sformatf("rs_nofim%0d", i));
    config_prog(4'b1111, 4'b0101, 8'd1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, f_ench(2'd0),      "rs_new_ench");
    step(1'b0, 1'b1, 1'b0, 1'b0, f_cheio(2'd0),     "rs_new_cheio");
    step(1'b0, 1'b1, 1'b0, 1'b0, f_asp(2'd0, 1'b1), "rs_new_z0");
    step(1'b0, 1'b1, 1'b0, 1'b0, f_cheio(2'd1),     "rs_new_cheio1");
    step(1'b0, 1'b1, 1'b0, 1'b0, f_got(2'd1),       "rs_new_z1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/irrigacao_multizona.md
Name: irrigacao_multizona

Overview:
Parametrised irrigation sequencer, successor to the single-line tank controller. Handles one shared reservoir and NUM_ZONES irrigation zones. Each zone is configured for sprinkler (aspersão) or drip (gotejamento) and watered for a programmable time, one zone after another. After the last zone it runs a timed cleaning cycle; it also has a fill timeout and a latched error state that must be acknowledged.

Parameters:
NUM_ZONES, 4, number of irrigation zones (2..16)
TIME_W, 8, width of the per-zone watering timer
CLEAN_CYCLES, 16, cycles the cleaning outputs stay active (>=1)
FILL_TIMEOUT, 200, maximum cycles in ENCHENDO before error (>=1)

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high; forces OCIOSO
Start  in  1  start request; also acknowledges ERRO
Nivel_Cheio  in  1  tank-full sensor
Nivel_Baixo  in  1  tank-low sensor
Erro_In  in  1  external fault
Agro_En  in  1  inject agrochemical on sprinkler zones
Zona_Habilita  in  NUM_ZONES  per-zone enable
Zona_Modo  in  NUM_ZONES  per-zone mode: 1 = aspersão, 0 = gotejamento
Tempo_Rega  in  TIME_W  watering cycles per zone
S_Enchendo  out  1  inlet valve open
S_Aspersao  out  NUM_ZONES  one-hot sprinkler valve
S_Gotejamento  out  NUM_ZONES  one-hot drip valve
S_Agro  out  1  agrochemical pump
S_Limpeza  out  1  cleaning active
S_SaidaLimpeza  out  1  cleaning drain valve
S_Erro  out  1  error indicator
S_Ocupado  out  1  high in any state except OCIOSO
S_Zona  out  $clog2(NUM_ZONES)  current zone pointer
S_Fim  out  1  one-cycle pulse when a full program completes

Behaviour:
- Reset is asynchronous and active-high. On Reset: state = OCIOSO, zone pointer = 0, timers = 0, and every output = 0.
- All outputs except S_Fim are a Moore decode of the registered state and pointer only. They change only after a Clock edge or Reset. S_Fim is registered.
- States are OCIOSO, ENCHENDO, CHEIO, REGANDO, LIMPEZA and ERRO.
- OCIOSO:
  - Start=1 latches Zona_Habilita, Zona_Modo, Tempo_Rega and Agro_En into shadow registers.
  - It also clears the pointer and fill counter, then goes to ENCHENDO.
  - Input changes after this latch have no effect until the next program.
- ENCHENDO:
  - S_Enchendo=1 and the fill counter increments every cycle.
  - Nivel_Cheio=1 goes to CHEIO.
  - If the counter reaches FILL_TIMEOUT-1 with Nivel_Cheio still 0, go to ERRO.
  - If the fill timeout and Nivel_Cheio occur in the same cycle, Nivel_Cheio wins.
- CHEIO (one cycle):
  - Search from the pointer upward for the lowest zone with enable=1 and latched Tempo_Rega != 0.
  - If found: set the pointer to it, load the timer with Tempo_Rega (first entry only, see the pause rule), go to REGANDO.
  - If none found: go to LIMPEZA.
- REGANDO:
  - For the zone at the pointer, drive its bit of S_Aspersao if its mode is 1, otherwise its bit of S_Gotejamento. All other bits are 0.
  - S_Agro = latched Agro_En AND mode=1.
  - The timer decrements each cycle, so the zone is active for exactly Tempo_Rega cycles.
  - When the timer reaches 1: increment the pointer and go to CHEIO. If the pointer was NUM_ZONES-1, go straight to LIMPEZA instead (no wrap).
  - Nivel_Baixo=1 pauses the zone: go to ENCHENDO with the pointer and remaining timer kept and the fill counter cleared. The following CHEIO resumes the same zone without reloading the timer. A "paused" flag distinguishes this from first entry.
- LIMPEZA:
  - S_Limpeza=1 and S_SaidaLimpeza=1 for exactly CLEAN_CYCLES cycles.
  - Then go to OCIOSO with S_Fim=1 for the one cycle after the exit edge.
- Error handling:
  - Erro_In=1 in any state other than OCIOSO and ERRO goes to ERRO on the next edge, and has priority over every other transition.
  - In ERRO, S_Erro=1 and all valves are 0.
  - ERRO is left only when Erro_In=0 and Start=1; the state goes to OCIOSO and no program starts.
  - In OCIOSO, Erro_In is ignored.
- Start is ignored in every state except OCIOSO and ERRO.
- Reset mid-program aborts immediately. S_Fim is not pulsed.

Test Plan:
- Basic program (NUM_ZONES=4, CLEAN_CYCLES=4):
  - Setup: Zona_Habilita=1111, Zona_Modo=0101, Tempo_Rega=3, Agro_En=1, Start; Nivel_Cheio=1 after 5 cycles.
  - Zones and modes: zones 0..3 each watered for 3 cycles. S_Aspersao[0] and [2] are active with S_Agro=1; S_Gotejamento[1] and [3] are active with S_Agro=0.
  - Ending: 4 cycles of S_Limpeza/S_SaidaLimpeza, then one S_Fim pulse.
- Zone skipping: Zona_Habilita=1010 -> only zones 1 and 3 are watered, and S_Zona goes 1 then 3. Tempo_Rega=0 -> no zone is watered and the program goes straight to LIMPEZA.
- Fill timeout: FILL_TIMEOUT=10 with Nivel_Cheio held 0 -> ERRO after 10 ENCHENDO cycles, S_Erro=1. Then Erro_In=0 with Start=1 -> OCIOSO and S_Ocupado=0.
- Low-level pause: Nivel_Baixo pulsed on the 2nd cycle of zone 1 with Tempo_Rega=5 -> S_Enchendo=1 until Nivel_Cheio. Zone 1 then resumes for the remaining 3 cycles, giving 5 cycles total.
- Error mid-watering: Erro_In=1 during REGANDO -> all valves 0 on the next edge and S_Erro=1. With Start=1 while Erro_In=1 the block stays in ERRO.
- Async reset: assert Reset during LIMPEZA, away from any clock edge -> all outputs 0 immediately, S_Fim never pulses, and the next Start runs a full program from zone 0.
